// File: rtl/test_chain_seq.sv
// rtl/test_chain_seq.sv - start/finish sequencer for a chain of test stages; optional watchdog via SEQ_WATCHDOG_EN
module test_chain_seq #(
  parameter int N_STAGES = 4,
  parameter int TIMEOUT  = 1024,
  parameter int IW       = (N_STAGES > 1) ? $clog2(N_STAGES) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                go,
  output logic [N_STAGES-1:0] stage_start,
  input  logic [N_STAGES-1:0] stage_finish,
  input  logic [N_STAGES-1:0] stage_pass,
  output logic                busy,
  output logic                done,
  output logic                all_pass,
  output logic [N_STAGES-1:0] fail_mask,
  output logic                timeout_err,
  output logic [IW-1:0]       cur_idx
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP, S_DONE} state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(N_STAGES - 1);

  if (N_STAGES < 1 || N_STAGES > 32 || TIMEOUT < 1) begin : g_param_check
    $error("test_chain_seq: N_STAGES must be 1..32 and TIMEOUT >= 1");
  end

  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [N_STAGES-1:0] start_q, start_d;
  logic [N_STAGES-1:0] fail_q, fail_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                launch;
  logic                fin_cur;
  logic                pass_cur;
  logic                expire;

  // Only the launched stage's handshake bits matter; the rest are don't-care.
  assign fin_cur  = stage_finish[idx_q];
  assign pass_cur = stage_pass[idx_q];
  assign launch   = go && (state_q == S_IDLE || state_q == S_DONE);

`ifdef SEQ_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);

  logic [WW-1:0] wdog_q, wdog_d;
  logic          tout_q, tout_d;

  assign expire      = (wdog_q == WDOG_LAST);
  assign timeout_err = tout_q;

  // Watchdog counts only while a stage keeps waiting; any exit from RUN clears it.
  always_comb begin
    wdog_d = '0;
    if (state_q == S_RUN && state_d == S_RUN) wdog_d = wdog_q + 1'b1;
    tout_d = tout_q;
    if (launch) tout_d = 1'b0;
    else if (state_q == S_RUN && !fin_cur && expire) tout_d = 1'b1;
  end

  // Watchdog registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= '0;
      tout_q <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      tout_q <= tout_d;
    end
  end
`else
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Sequencer next state; finish beats an expiring watchdog in the same cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    fail_d  = fail_q;
    busy_d  = busy_q;
    done_d  = done_q;
    start_d = '0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (launch) begin
          state_d = S_RUN;
          idx_d   = '0;
          fail_d  = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      S_RUN: begin
        if (fin_cur) begin
          fail_d[idx_q] = ~pass_cur;
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = S_GAP;
          end
        end else if (expire) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      S_GAP: begin
        idx_d   = idx_q + 1'b1;
        state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
    // Start is registered from the next state so it aligns with RUN exactly.
    if (state_d == S_RUN) start_d = N_STAGES'(1) << idx_d;
  end

  // Sequencer registers; async reset drops stage_start immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      start_q <= '0;
      fail_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      start_q <= start_d;
      fail_q  <= fail_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign stage_start = start_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign fail_mask   = fail_q;
  assign cur_idx     = idx_q;
  assign all_pass    = done_q & ~|fail_q & ~timeout_err;

endmodule
